// File: rtl/truth_table_eval_seq_if.sv
// Handshake and configuration bundle for truth_table_eval_seq.
// The master modport is the driving side; the slave modport is the evaluator.
interface truth_table_eval_seq_if #(
   parameter int N_IN  = 3,
   parameter int N_OUT = 1
);
   logic              cfg_start;
   logic              cfg_valid;
   logic              cfg_bit;
   logic              cfg_busy;
   logic              in_valid;
   logic              in_ready;
   logic [N_IN-1:0]   in_vec;
   logic              out_valid;
   logic              out_ready;
   logic [N_OUT-1:0]  out_vec;
   logic [15:0]       eval_count;

   modport master (
      output cfg_start, cfg_valid, cfg_bit, in_valid, in_vec, out_ready,
      input  cfg_busy, in_ready, out_valid, out_vec, eval_count
   );

   modport slave (
      input  cfg_start, cfg_valid, cfg_bit, in_valid, in_vec, out_ready,
      output cfg_busy, in_ready, out_valid, out_vec, eval_count
   );
endinterface

// File: rtl/truth_table_eval_seq.sv
// Reprogrammable N_IN-input / N_OUT-output truth-table evaluator with a valid/ready
// input, a one-entry registered output stage and a serially reloaded table.
module truth_table_eval_seq #(
   parameter int                          N_IN        = 3,
   parameter int                          N_OUT       = 1,
   parameter logic [(2**N_IN)*N_OUT-1:0]  RESET_TABLE = 8'h70
) (
   input logic                    clk,
   input logic                    rst,
   truth_table_eval_seq_if.slave  bus
);
   localparam int DEPTH = 2**N_IN;
   localparam int TBITS = DEPTH*N_OUT;
   localparam int CNT_W = $clog2(TBITS);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(TBITS-1);

   typedef enum logic [1:0] {
      S_RUN   = 2'd0,
      S_DRAIN = 2'd1,
      S_LOAD  = 2'd2
   } state_t;

   state_t              r_state;
   logic [TBITS-1:0]    r_table;
   logic [TBITS-1:0]    r_shadow;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_out_valid;
   logic [N_OUT-1:0]    r_out_vec;
   logic [15:0]         r_eval_count;
   logic                r_cfg_busy;

   state_t              w_next_state;
   logic                w_in_ready;
   logic                w_bit_we;
   logic                w_load_done;
   logic                w_accept;
   logic                w_xfer;
   logic [N_OUT-1:0]    w_row;
   logic [TBITS-1:0]    w_shadow_nxt;

   assign w_accept = bus.in_valid && w_in_ready;
   assign w_xfer   = r_out_valid && bus.out_ready;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_RUN;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state and per-state control.
   always_comb begin
      w_next_state = r_state;
      w_in_ready   = 1'b0;
      w_bit_we     = 1'b0;
      w_load_done  = 1'b0;
      case (r_state)
         S_RUN: begin
            w_in_ready = !r_out_valid || bus.out_ready;
            if (bus.cfg_start) begin
               w_next_state = S_DRAIN;
            end else begin
               w_next_state = S_RUN;
            end
         end
         S_DRAIN: begin
            // The pending result must leave under the old table before loading.
            if (!r_out_valid) begin
               w_next_state = S_LOAD;
            end else begin
               w_next_state = S_DRAIN;
            end
         end
         S_LOAD: begin
            w_bit_we = bus.cfg_valid;
            if (bus.cfg_valid && (r_cnt == LAST_BIT)) begin
               w_load_done  = 1'b1;
               w_next_state = S_RUN;
            end else begin
               w_next_state = S_LOAD;
            end
         end
         default: begin
            w_next_state = S_RUN;
         end
      endcase
   end

   // Shadow table with the current serial bit merged in.
   always_comb begin
      w_shadow_nxt = r_shadow;
      if (w_bit_we) begin
         w_shadow_nxt[r_cnt] = bus.cfg_bit;
      end else begin
         w_shadow_nxt = r_shadow;
      end
   end

   // Row select from the active table.
   always_comb begin
      w_row = {N_OUT{1'b0}};
      for (int r = 0; r < DEPTH; r++) begin
         if (bus.in_vec == N_IN'(r)) begin
            w_row = r_table[r*N_OUT +: N_OUT];
         end else begin
            w_row = w_row;
         end
      end
   end

   // Table storage: the active table only changes on the edge of the last bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_table  <= RESET_TABLE;
         r_shadow <= RESET_TABLE;
         r_cnt    <= {CNT_W{1'b0}};
      end else if (w_load_done) begin
         r_table  <= w_shadow_nxt;
         r_shadow <= w_shadow_nxt;
         r_cnt    <= {CNT_W{1'b0}};
      end else if (w_bit_we) begin
         r_shadow <= w_shadow_nxt;
         r_cnt    <= r_cnt + CNT_W'(1);
      end
   end

   // One-entry output stage: refill on accept, empty on an unreplaced transfer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_vec   <= {N_OUT{1'b0}};
      end else if (w_accept) begin
         r_out_valid <= 1'b1;
         r_out_vec   <= w_row;
      end else if (w_xfer) begin
         r_out_valid <= 1'b0;
      end
   end

   // Completed-transfer counter, wrapping naturally at 16 bits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_eval_count <= 16'd0;
      end else if (w_xfer) begin
         r_eval_count <= r_eval_count + 16'd1;
      end
   end

   // Busy flag tracks the LOAD state one-for-one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cfg_busy <= 1'b0;
      end else begin
         r_cfg_busy <= (w_next_state == S_LOAD);
      end
   end

   assign bus.cfg_busy   = r_cfg_busy;
   assign bus.in_ready   = w_in_ready;
   assign bus.out_valid  = r_out_valid;
   assign bus.out_vec    = r_out_vec;
   assign bus.eval_count = r_eval_count;
endmodule

// File: tb/tb_truth_table_eval_seq.sv
// Scoreboard bench for truth_table_eval_seq: directed vectors push expected rows,
// independent monitors pop and compare on every output transfer.
module tb_truth_table_eval_seq;
   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_errors = 0;
   int   exp_cnt1 = 0;
   int   exp_cnt2 = 0;
   logic [7:0] q1[$];
   logic [7:0] q2[$];
   logic [7:0]  t70;
   logic [31:0] t2;

   always #5 clk = ~clk;

   truth_table_eval_seq_if #(.N_IN(3), .N_OUT(1)) bus1();
   truth_table_eval_seq_if #(.N_IN(4), .N_OUT(2)) bus2();

   truth_table_eval_seq #(.N_IN(3), .N_OUT(1), .RESET_TABLE(8'h70)) dut1 (
      .clk(clk), .rst(rst), .bus(bus1.slave));
   truth_table_eval_seq #(.N_IN(4), .N_OUT(2), .RESET_TABLE(32'hE4E4_E4E4)) dut2 (
      .clk(clk), .rst(rst), .bus(bus2.slave));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   // Monitors: compare each transfer against the oldest queued expectation.
   always @(negedge clk) begin
      if (rst === 1'b0 && bus1.out_valid === 1'b1 && bus1.out_ready === 1'b1) begin
         if (q1.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb1_unexpected: actual=%0h expected=no output", bus1.out_vec);
         end else begin
            chk("sb1_out_vec", 32'(bus1.out_vec), 32'(q1.pop_front()));
         end
         exp_cnt1 = (exp_cnt1 + 1) & 32'hFFFF;
      end
      if (rst === 1'b0 && bus2.out_valid === 1'b1 && bus2.out_ready === 1'b1) begin
         if (q2.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb2_unexpected: actual=%0h expected=no output", bus2.out_vec);
         end else begin
            chk("sb2_out_vec", 32'(bus2.out_vec), 32'(q2.pop_front()));
         end
         exp_cnt2 = (exp_cnt2 + 1) & 32'hFFFF;
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL global_timeout: actual=running expected=finished");
      $fatal(1);
   end

   // Tasks start and end at posedge+1 unless noted.
   task automatic send1(input logic [2:0] v, input logic e);
      int w = 0;
      bus1.in_vec = v;
      bus1.in_valid = 1'b1;
      @(negedge clk);
      while (bus1.in_ready !== 1'b1 && w < 50) begin
         @(negedge clk);
         w++;
      end
      chk("send1_ready", 32'(bus1.in_ready), 32'd1);
      if (w < 50) q1.push_back(8'(e));
      @(posedge clk); #1;
      bus1.in_valid = 1'b0;
      if (w < 50) begin
         chk("lat1_valid", 32'(bus1.out_valid), 32'd1);
         chk("lat1_vec", 32'(bus1.out_vec), 32'(e));
      end
   endtask

   task automatic send2(input logic [3:0] v, input logic [1:0] e);
      int w = 0;
      bus2.in_vec = v;
      bus2.in_valid = 1'b1;
      @(negedge clk);
      while (bus2.in_ready !== 1'b1 && w < 50) begin
         @(negedge clk);
         w++;
      end
      chk("send2_ready", 32'(bus2.in_ready), 32'd1);
      if (w < 50) q2.push_back(8'(e));
      @(posedge clk); #1;
      bus2.in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse1();
      bus1.cfg_start = 1'b1;
      @(posedge clk); #1;
      bus1.cfg_start = 1'b0;
   endtask

   task automatic pulse2();
      bus2.cfg_start = 1'b1;
      @(posedge clk); #1;
      bus2.cfg_start = 1'b0;
   endtask

   task automatic shift1(input logic [7:0] tbl, input int nbits, input bit gaps);
      int w = 0;
      @(negedge clk);
      while (bus1.cfg_busy !== 1'b1 && w < 50) begin
         @(negedge clk);
         w++;
      end
      chk("cfg1_busy_start", 32'(bus1.cfg_busy), 32'd1);
      chk("cfg1_in_ready_load", 32'(bus1.in_ready), 32'd0);
      for (int i = 0; i < nbits; i++) begin
         if (gaps && (i % 3 == 1)) begin
            bus1.cfg_valid = 1'b0;
            bus1.cfg_start = (i == 1);
            @(negedge clk);
            bus1.cfg_start = 1'b0;
            chk("cfg1_busy_gap", 32'(bus1.cfg_busy), 32'd1);
         end
         bus1.cfg_valid = 1'b1;
         bus1.cfg_bit = tbl[i];
         @(negedge clk);
         bus1.cfg_valid = 1'b0;
         chk("cfg1_busy_bit", 32'(bus1.cfg_busy), (i == 7) ? 32'd0 : 32'd1);
      end
      @(posedge clk); #1;
   endtask

   task automatic shift2(input logic [31:0] tbl);
      int w = 0;
      @(negedge clk);
      while (bus2.cfg_busy !== 1'b1 && w < 50) begin
         @(negedge clk);
         w++;
      end
      chk("cfg2_busy_start", 32'(bus2.cfg_busy), 32'd1);
      for (int i = 0; i < 32; i++) begin
         bus2.cfg_valid = 1'b1;
         bus2.cfg_bit = tbl[i];
         @(negedge clk);
         bus2.cfg_valid = 1'b0;
         chk("cfg2_busy_bit", 32'(bus2.cfg_busy), (i == 31) ? 32'd0 : 32'd1);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      int n;
      rst = 1'b1;
      bus1.cfg_start = 1'b0; bus1.cfg_valid = 1'b0; bus1.cfg_bit = 1'b0;
      bus1.in_valid = 1'b0; bus1.in_vec = 3'd0; bus1.out_ready = 1'b0;
      bus2.cfg_start = 1'b0; bus2.cfg_valid = 1'b0; bus2.cfg_bit = 1'b0;
      bus2.in_valid = 1'b0; bus2.in_vec = 4'd0; bus2.out_ready = 1'b0;
      t70 = 8'h70;

      // Reset defaults.
      repeat (2) @(negedge clk);
      chk("rst_out_valid", 32'(bus1.out_valid), 32'd0);
      chk("rst_out_vec", 32'(bus1.out_vec), 32'd0);
      chk("rst_cfg_busy", 32'(bus1.cfg_busy), 32'd0);
      chk("rst_eval_count", 32'(bus1.eval_count), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", 32'(bus1.in_ready), 32'd1);
      idle(1);

      // Reset table stream, stray cfg_valid in RUN must not touch the table.
      bus1.out_ready = 1'b1;
      bus1.cfg_valid = 1'b1;
      bus1.cfg_bit = 1'b1;
      for (int v = 0; v < 8; v++) send1(3'(v), t70[v]);
      bus1.cfg_valid = 1'b0;
      idle(3);
      chk("cnt_after_stream", 32'(bus1.eval_count), 32'd8);

      // Backpressure holds the result and blocks input.
      bus1.out_ready = 1'b0;
      send1(3'b100, 1'b1);
      repeat (5) begin
         @(negedge clk);
         chk("bp_out_valid", 32'(bus1.out_valid), 32'd1);
         chk("bp_out_vec", 32'(bus1.out_vec), 32'd1);
         chk("bp_in_ready", 32'(bus1.in_ready), 32'd0);
      end
      @(posedge clk); #1;
      bus1.out_ready = 1'b1;
      #1;
      chk("bp_release_in_ready", 32'(bus1.in_ready), 32'd1);
      @(negedge clk);
      @(negedge clk);
      chk("bp_drained", 32'(bus1.out_valid), 32'd0);
      chk("bp_count", 32'(bus1.eval_count), 32'd9);
      @(posedge clk); #1;

      // Reload XOR3 with gaps and an ignored cfg_start mid-load.
      pulse1();
      shift1(8'h96, 8, 1'b1);
      send1(3'b111, 1'b1);
      send1(3'b100, 1'b1);
      send1(3'b011, 1'b0);
      send1(3'b000, 1'b0);
      idle(2);

      // Drain ordering: pending result keeps the old table, LOAD waits for it.
      bus1.out_ready = 1'b0;
      send1(3'b001, 1'b1);
      pulse1();
      repeat (4) begin
         @(negedge clk);
         chk("drain_busy", 32'(bus1.cfg_busy), 32'd0);
         chk("drain_out_vec", 32'(bus1.out_vec), 32'd1);
         chk("drain_in_ready", 32'(bus1.in_ready), 32'd0);
      end
      @(posedge clk); #1;
      bus1.out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("drain_gap_busy", 32'(bus1.cfg_busy), 32'd0);
      chk("drain_gap_in_ready", 32'(bus1.in_ready), 32'd0);
      @(posedge clk); #1;
      shift1(8'hE8, 8, 1'b0);
      send1(3'b001, 1'b0);
      send1(3'b011, 1'b1);
      send1(3'b100, 1'b0);
      idle(3);
      chk("cnt_model_a", 32'(bus1.eval_count), 32'(exp_cnt1));

      // Async reset in the middle of a load.
      pulse1();
      shift1(8'h00, 4, 1'b0);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_busy", 32'(bus1.cfg_busy), 32'd0);
      chk("mid_rst_count", 32'(bus1.eval_count), 32'd0);
      chk("mid_rst_out_valid", 32'(bus1.out_valid), 32'd0);
      exp_cnt1 = 0;
      exp_cnt2 = 0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      send1(3'b101, 1'b1);
      send1(3'b011, 1'b0);
      send1(3'b100, 1'b1);
      send1(3'b000, 1'b0);
      idle(3);
      chk("cnt_after_rst", 32'(bus1.eval_count), 32'd4);

      // Counter wrap.
      n = 65535 - exp_cnt1;
      for (int k = 0; k < n; k++) send1(3'b110, 1'b1);
      idle(3);
      chk("cnt_ffff", 32'(bus1.eval_count), 32'h0000_FFFF);
      send1(3'b110, 1'b1);
      idle(3);
      chk("cnt_wrap", 32'(bus1.eval_count), 32'd0);
      chk("cnt_wrap_model", 32'(bus1.eval_count), 32'(exp_cnt1));

      // Second instance: N_IN=4, N_OUT=2.
      bus2.out_ready = 1'b1;
      send2(4'd5, 2'b01);
      t2 = 32'hC3A5_1E69;
      pulse2();
      shift2(t2);
      for (int v = 0; v < 16; v++) send2(4'(v), t2[2*v +: 2]);
      idle(3);
      chk("cnt2", 32'(bus2.eval_count), 32'd17);
      chk("cnt2_model", 32'(bus2.eval_count), 32'(exp_cnt2));

      chk("sb1_empty", 32'(q1.size()), 32'd0);
      chk("sb2_empty", 32'(q2.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/truth_table_eval_seq.md
Name: truth_table_eval_seq

Overview:
- Registered, reprogrammable truth-table evaluator for sampled combinational logic functions.
- Generalises fixed 3-input/1-output case-table gates to N_IN inputs and N_OUT outputs.
- The table is loaded at runtime over a serial config port; no re-synthesis is needed.
- Input vectors enter through a valid/ready handshake; results leave through a one-entry registered output stage with backpressure.

Parameters:
- N_IN, 3, input vector width; table depth is 2^N_IN rows (1..6 supported).
- N_OUT, 1, output bits per row.
- RESET_TABLE, 8'h70, table contents after reset, width (2^N_IN)*N_OUT. Row r occupies bits [r*N_OUT +: N_OUT]. Row index = input vector, MSB = first input.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- cfg_start  input  1  pulse; begins a table reload.
- cfg_valid  input  1  cfg_bit is valid this cycle.
- cfg_bit  input  1  serial table bit, row 0 bit 0 first, ascending.
- cfg_busy  output  1  high while LOAD is in progress.
- in_valid  input  1  in_vec is valid.
- in_ready  output  1  block accepts in_vec this cycle.
- in_vec  input  N_IN  input vector; also the row index.
- out_valid  output  1  out_vec holds a result.
- out_ready  input  1  downstream accepts the result.
- out_vec  output  N_OUT  table row for the accepted in_vec.
- eval_count  output  16  number of completed output transfers; wraps 16'hFFFF -> 0.

Behaviour:
- Reset (async assert; deassert is sampled on clk):
  - table = RESET_TABLE, state = RUN.
  - out_valid = 0, out_vec = 0, cfg_busy = 0, eval_count = 0, load counter = 0.
- State RUN:
  - in_ready = !out_valid || out_ready (one-entry stage; full throughput when drained).
  - Accept occurs when in_valid && in_ready. On the next edge: out_vec = table[in_vec row], out_valid = 1. Latency is 1 cycle.
  - Output transfer occurs when out_valid && out_ready. If there is no simultaneous accept, out_valid clears next edge and eval_count increments.
  - Simultaneous accept and transfer: out_valid stays 1, out_vec takes the new row, eval_count increments.
  - out_vec and out_valid are held stable while out_valid && !out_ready.
- cfg_start in RUN: go to DRAIN. If cfg_start and an accept occur in the same cycle, the accept still completes.
- State DRAIN:
  - in_ready = 0.
  - Wait until out_valid == 0 (pending result delivered using the old table), then go to LOAD.
  - If out_valid is already 0, go to LOAD on the next edge.
- State LOAD:
  - cfg_busy = 1, in_ready = 0.
  - Each cfg_valid cycle writes cfg_bit into the shadow table at the load counter position, then increments the counter.
  - When the counter reaches (2^N_IN)*N_OUT - 1 and cfg_valid is high:
    - the shadow table is copied to the active table on that edge;
    - the counter clears;
    - the state returns to RUN.
  - cfg_busy drops the cycle after the last bit. The first accept with the new table is possible the cycle after that.
- The active table never changes during a partial load. Evaluations always see either the old or the new table, never a mix.
- cfg_start during DRAIN or LOAD is ignored; the load is not restarted.
- cfg_valid outside LOAD is ignored.
- Reset mid-LOAD: shadow data is discarded and the table returns to RESET_TABLE.
- in_vec values are always in range; no X propagation from the table is allowed after reset.

Test Plan:
- Reset defaults, N_IN=3/N_OUT=1: stream in_vec 0..7 with out_ready=1 -> out_vec 0,0,0,0,1,1,1,0. Each result appears 1 cycle after its accept; eval_count = 8.
- Backpressure: out_ready=0 for 5 cycles after accepting 3'b100 -> out_vec=1 stays stable, in_ready=0. Releasing out_ready gives one transfer; in_ready=1 in the same cycle.
- Reload: cfg_start, then shift bits for table 8'h96 (XOR3) with gaps in cfg_valid -> cfg_busy is high for exactly the load duration, and in_vec 3'b111 then yields 1.
- Drain ordering: hold a pending result (out_ready=0), pulse cfg_start -> the pending out_vec still reflects the old table and LOAD does not begin until it transfers.
- Async reset mid-LOAD after 4 bits -> table reverts to 8'h70, and 3'b101 -> 1 after recovery.
- Counter wrap: preload via 65536 transfers -> eval_count wraps 16'hFFFF -> 16'h0000.
- Parameter sweep N_IN=4, N_OUT=2: random table load, then exhaustive 16 vectors compared against the loaded rows.
